// File: rtl/hazard_pkg.sv
// Shared types, encodings and parameter checks for the hazard scoreboard.
package hazard_pkg;

  // Widest register address any instance may use; entries store rd at this width.
  localparam int unsigned RA_W_MAX = 16;

  // Operand select value meaning "read the register file".
  localparam int unsigned FWD_RF = 0;

  // One in-flight instruction tracked past issue.
  typedef struct packed {
    logic                valid;
    logic [RA_W_MAX-1:0] rd;
    logic                wen;
    logic                load;
  } entryT;

  // True when the parameter set is one the scoreboard supports.
  function automatic bit paramsLegal(input int unsigned stages,
                                     input int unsigned raW,
                                     input int unsigned loadStage,
                                     input int unsigned flushDepth);
    bit ok;
    ok = (stages >= 1) && (stages <= 8) &&
         (raW >= 1) && (raW <= RA_W_MAX) &&
         (flushDepth <= stages);
    if (stages > 1) ok = ok && (loadStage >= 1) && (loadStage <= stages - 1);
    else            ok = ok && (loadStage == 1);
    return ok;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Per-entry comparator: forwardable hits on rs/rt and load-not-yet-ready hits.
module hazard_match
  import hazard_pkg::*;
#(
  parameter bit EARLY = 1'b0  // entry sits before the first load-forwarding stage
) (
  input  entryT               entry,
  input  logic [RA_W_MAX-1:0] rs,
  input  logic [RA_W_MAX-1:0] rt,
  input  logic                useRs,
  input  logic                useRt,
  output logic                fwdRs_c,
  output logic                fwdRt_c,
  output logic                loadHit_c
);

  logic hitRs;
  logic hitRt;
  logic pending;

  // Register 0 never matches; an early load cannot forward, it stalls instead.
  always_comb begin
    hitRs     = entry.valid & entry.wen & (entry.rd == rs) & (rs != '0) & useRs;
    hitRt     = entry.valid & entry.wen & (entry.rd == rt) & (rt != '0) & useRt;
    pending   = entry.load & EARLY;
    fwdRs_c   = hitRs & ~pending;
    fwdRt_c   = hitRt & ~pending;
    loadHit_c = pending & (hitRs | hitRt);
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order pipeline hazard scoreboard: forwarding selects, load-use stall, bubble, stall counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned STAGES      = 2,
  parameter int unsigned RA_W        = 5,
  parameter int unsigned LOAD_STAGE  = 1,
  parameter int unsigned FLUSH_DEPTH = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         issue_valid,
  input  logic                         issue_is_load,
  input  logic                         issue_wen,
  input  logic                         issue_use_rs,
  input  logic                         issue_use_rt,
  input  logic [RA_W-1:0]              issue_rs,
  input  logic [RA_W-1:0]              issue_rt,
  input  logic [RA_W-1:0]              issue_rd,
  input  logic                         hold_ext,
  input  logic                         flush,
  output logic                         stall,
  output logic                         bubble,
  output logic [$clog2(STAGES+1)-1:0]  fwd_a,
  output logic [$clog2(STAGES+1)-1:0]  fwd_b,
  output logic [31:0]                  stall_cnt
);

  localparam int unsigned FWD_W = $clog2(STAGES + 1);

  // Reject unsupported parameter sets while elaborating.
  if (!paramsLegal(STAGES, RA_W, LOAD_STAGE, FLUSH_DEPTH)) begin : gBadParams
    $error("hazard_scoreboard: illegal parameter combination");
  end

  entryT               pipe     [STAGES];
  entryT               pipeNext [STAGES];
  entryT               issueEntry;
  logic [RA_W_MAX-1:0] rsExt;
  logic [RA_W_MAX-1:0] rtExt;
  logic [STAGES-1:0]   fwdRs;
  logic [STAGES-1:0]   fwdRt;
  logic [STAGES-1:0]   loadHit;
  logic                lu;

  assign rsExt = RA_W_MAX'(issue_rs);
  assign rtExt = RA_W_MAX'(issue_rt);

  // One comparator per tracked stage.
  for (genvar k = 0; k < int'(STAGES); k++) begin : gMatch
    hazard_match #(
      .EARLY (bit'(k < int'(LOAD_STAGE)))
    ) uMatch (
      .entry     (pipe[k]),
      .rs        (rsExt),
      .rt        (rtExt),
      .useRs     (issue_use_rs),
      .useRt     (issue_use_rt),
      .fwdRs_c   (fwdRs[k]),
      .fwdRt_c   (fwdRt[k]),
      .loadHit_c (loadHit[k])
    );
  end

  // Youngest-match-wins forwarding select plus stall/bubble decode.
  always_comb begin
    fwd_a = FWD_W'(FWD_RF);
    fwd_b = FWD_W'(FWD_RF);
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      if (fwdRs[k]) fwd_a = FWD_W'(k + 1);
      if (fwdRt[k]) fwd_b = FWD_W'(k + 1);
    end
    lu     = issue_valid & (|loadHit);
    stall  = lu | hold_ext;
    bubble = (lu | flush) & ~hold_ext;
  end

  // Post-edge entry contents when the pipeline advances.
  always_comb begin
    issueEntry       = '0;
    issueEntry.valid = issue_valid & ~lu & ~flush;
    issueEntry.rd    = RA_W_MAX'(issue_rd);
    issueEntry.wen   = issue_wen;
    issueEntry.load  = issue_is_load;
    pipeNext         = pipe;
    pipeNext[0]      = issueEntry;
    for (int k = 1; k < int'(STAGES); k++) pipeNext[k] = pipe[k-1];
    for (int k = 0; k < int'(STAGES); k++) begin
      if (flush && (k < int'(FLUSH_DEPTH))) pipeNext[k].valid = 1'b0;
    end
  end

  // Entry shift register and saturating load-use stall counter; hold_ext freezes both.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < int'(STAGES); k++) pipe[k] <= '0;
      stall_cnt <= '0;
    end else if (!hold_ext) begin
      pipe <= pipeNext;
      if (lu && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: default-parameter scoreboard plus a 4-stage, LOAD_STAGE=2, FLUSH_DEPTH=2 instance.
module tb_hazard_scoreboard;

  typedef struct {
    bit v, ld, wen, urs, urt;
    int rs, rt, rd;
    bit hold, flush;
    int eStall, eBub, eFa, eFb, eCnt;
  } vecT;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Default instance signals
  logic       v1, ld1, wen1, urs1, urt1, hold1, flush1;
  logic [4:0] rs1, rt1, rd1;
  logic       stall1, bub1;
  logic [1:0] fa1, fb1;
  logic [31:0] cnt1;

  // Deep instance signals
  logic       v2, ld2, wen2, urs2, urt2, hold2, flush2;
  logic [4:0] rs2, rt2, rd2;
  logic       stall2, bub2;
  logic [2:0] fa2, fb2;
  logic [31:0] cnt2;

  int total = 0;
  int bad   = 0;

  hazard_scoreboard dut1 (
    .clk(clk), .reset(reset),
    .issue_valid(v1), .issue_is_load(ld1), .issue_wen(wen1),
    .issue_use_rs(urs1), .issue_use_rt(urt1),
    .issue_rs(rs1), .issue_rt(rt1), .issue_rd(rd1),
    .hold_ext(hold1), .flush(flush1),
    .stall(stall1), .bubble(bub1), .fwd_a(fa1), .fwd_b(fb1), .stall_cnt(cnt1)
  );

  hazard_scoreboard #(.STAGES(4), .RA_W(5), .LOAD_STAGE(2), .FLUSH_DEPTH(2)) dut2 (
    .clk(clk), .reset(reset),
    .issue_valid(v2), .issue_is_load(ld2), .issue_wen(wen2),
    .issue_use_rs(urs2), .issue_use_rt(urt2),
    .issue_rs(rs2), .issue_rt(rt2), .issue_rd(rd2),
    .hold_ext(hold2), .flush(flush2),
    .stall(stall2), .bubble(bub2), .fwd_a(fa2), .fwd_b(fb2), .stall_cnt(cnt2)
  );

  function automatic vecT mk(bit v, bit ld, bit wen, bit urs, bit urt,
                             int rs, int rt, int rd, bit hold, bit flush,
                             int eStall, int eBub, int eFa, int eFb, int eCnt);
    vecT t;
    t.v = v; t.ld = ld; t.wen = wen; t.urs = urs; t.urt = urt;
    t.rs = rs; t.rt = rt; t.rd = rd; t.hold = hold; t.flush = flush;
    t.eStall = eStall; t.eBub = eBub; t.eFa = eFa; t.eFb = eFb; t.eCnt = eCnt;
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input vecT t);
    if (!sel) begin
      v1 = t.v; ld1 = t.ld; wen1 = t.wen; urs1 = t.urs; urt1 = t.urt;
      rs1 = 5'(t.rs); rt1 = 5'(t.rt); rd1 = 5'(t.rd); hold1 = t.hold; flush1 = t.flush;
    end else begin
      v2 = t.v; ld2 = t.ld; wen2 = t.wen; urs2 = t.urs; urt2 = t.urt;
      rs2 = 5'(t.rs); rt2 = 5'(t.rt); rd2 = 5'(t.rd); hold2 = t.hold; flush2 = t.flush;
    end
  endtask

  task automatic check(input bit sel, input vecT t, input string tag);
    if (!sel) begin
      chk({tag, ".stall"},  int'(stall1), t.eStall);
      chk({tag, ".bubble"}, int'(bub1),   t.eBub);
      chk({tag, ".fwd_a"},  int'(fa1),    t.eFa);
      chk({tag, ".fwd_b"},  int'(fb1),    t.eFb);
      chk({tag, ".cnt"},    int'(cnt1),   t.eCnt);
    end else begin
      chk({tag, ".stall"},  int'(stall2), t.eStall);
      chk({tag, ".bubble"}, int'(bub2),   t.eBub);
      chk({tag, ".fwd_a"},  int'(fa2),    t.eFa);
      chk({tag, ".fwd_b"},  int'(fb2),    t.eFb);
      chk({tag, ".cnt"},    int'(cnt2),   t.eCnt);
    end
  endtask

  // Drive at posedge+1, compare at negedge, then advance one clock.
  task automatic step(input bit sel, input vecT t, input string tag);
    drive(sel, t);
    @(negedge clk);
    check(sel, t, tag);
    @(posedge clk);
    #1;
  endtask

  vecT tab1[$];
  vecT tab2[$];
  vecT idle;

  initial begin
    //          v ld w rs rt  rs  rt  rd  h  f   st bu fa fb cnt
    idle = mk(0,0,0,0,0,   0,  0,  0, 0, 0,  0, 0, 0, 0, 0);

    // Default instance: forwarding distances, load-use, unused operands, r0, youngest-wins, flush, hold
    tab1.push_back(mk(0,0,0,0,0,  0, 0, 0, 0,0, 0,0,0,0,0)); // 0 idle
    tab1.push_back(mk(1,0,1,0,0,  0, 0, 3, 0,0, 0,0,0,0,0)); // 1 add r3
    tab1.push_back(mk(1,0,0,1,0,  3, 0, 0, 0,0, 0,0,1,0,0)); // 2 read r3 from E
    tab1.push_back(mk(1,0,0,1,0,  3, 0, 0, 0,0, 0,0,2,0,0)); // 3 read r3 from M
    tab1.push_back(mk(1,0,1,0,0,  0, 0, 9, 0,0, 0,0,0,0,0)); // 4 add r9
    tab1.push_back(mk(0,0,0,0,0,  0, 0, 0, 0,0, 0,0,0,0,0)); // 5 NOP
    tab1.push_back(mk(1,0,0,1,1,  9, 9, 0, 0,0, 0,0,2,2,0)); // 6 read r9 both ports
    tab1.push_back(mk(1,1,1,0,0,  0, 0, 5, 0,0, 0,0,0,0,0)); // 7 lw r5
    tab1.push_back(mk(1,0,1,0,1,  0, 5, 6, 0,0, 1,1,0,0,0)); // 8 use rt=r5: stall
    tab1.push_back(mk(1,0,1,0,1,  0, 5, 6, 0,0, 0,0,0,2,1)); // 9 replay: fwd from M
    tab1.push_back(mk(1,1,1,0,0,  0, 0, 5, 0,0, 0,0,0,0,1)); // 10 lw r5
    tab1.push_back(mk(1,0,0,0,0,  5, 5, 0, 0,0, 0,0,0,0,1)); // 11 operands unused
    tab1.push_back(mk(1,0,1,0,0,  0, 0, 0, 0,0, 0,0,0,0,1)); // 12 write r0
    tab1.push_back(mk(1,0,0,1,1,  0, 0, 0, 0,0, 0,0,0,0,1)); // 13 read r0
    tab1.push_back(mk(1,0,1,0,0,  0, 0, 7, 0,0, 0,0,0,0,1)); // 14 write r7
    tab1.push_back(mk(1,0,1,1,0,  7, 0, 7, 0,0, 0,0,1,0,1)); // 15 write r7 again
    tab1.push_back(mk(1,0,0,1,1,  7, 7, 0, 0,0, 0,0,1,1,1)); // 16 youngest r7 wins
    tab1.push_back(mk(1,0,1,0,0,  0, 0, 4, 0,0, 0,0,0,0,1)); // 17 write r4
    tab1.push_back(mk(1,0,1,0,0,  0, 0,10, 0,1, 0,1,0,0,1)); // 18 flush kills r10 writer
    tab1.push_back(mk(1,0,0,1,1, 10, 4, 0, 0,0, 0,0,0,2,1)); // 19 r10 gone, r4 survives
    tab1.push_back(mk(1,1,1,0,0,  0, 0, 5, 0,0, 0,0,0,0,1)); // 20 lw r5
    tab1.push_back(mk(1,0,0,0,1,  0, 5, 0, 0,1, 1,1,0,0,1)); // 21 flush during load-use
    tab1.push_back(mk(0,0,0,0,0,  0, 0, 0, 0,0, 0,0,0,0,2)); // 22 idle
    tab1.push_back(mk(1,1,1,0,0,  0, 0, 5, 0,0, 0,0,0,0,2)); // 23 lw r5
    tab1.push_back(mk(1,0,0,1,0,  5, 0, 0, 1,0, 1,0,0,0,2)); // 24 hold over load-use
    tab1.push_back(mk(1,0,0,1,0,  5, 0, 0, 1,1, 1,0,0,0,2)); // 25 hold beats flush
    tab1.push_back(mk(1,0,0,1,0,  5, 0, 0, 1,0, 1,0,0,0,2)); // 26 hold
    tab1.push_back(mk(1,0,0,1,0,  5, 0, 0, 0,0, 1,1,0,0,2)); // 27 release: stall
    tab1.push_back(mk(1,0,0,1,0,  5, 0, 0, 0,0, 0,0,2,0,3)); // 28 fwd from M
    tab1.push_back(mk(0,0,0,0,0,  0, 0, 0, 0,0, 0,0,0,0,3)); // 29 idle

    // Deep instance: two-cycle load-use, deeper forward, two-entry flush
    tab2.push_back(mk(0,0,0,0,0,  0, 0, 0, 0,0, 0,0,0,0,0)); // 0 idle
    tab2.push_back(mk(1,1,1,0,0,  0, 0, 5, 0,0, 0,0,0,0,0)); // 1 lw r5
    tab2.push_back(mk(1,0,1,1,0,  5, 0,12, 0,0, 1,1,0,0,0)); // 2 stall 1
    tab2.push_back(mk(1,0,1,1,0,  5, 0,12, 0,0, 1,1,0,0,1)); // 3 stall 2
    tab2.push_back(mk(1,0,1,1,0,  5, 0,12, 0,0, 0,0,3,0,2)); // 4 fwd from stage 2
    tab2.push_back(mk(1,0,1,0,0,  0, 0, 4, 0,0, 0,0,0,0,2)); // 5 write r4
    tab2.push_back(mk(1,0,1,1,0,  4, 0,11, 0,1, 0,1,1,0,2)); // 6 flush
    tab2.push_back(mk(1,0,0,1,1,  4,12, 0, 0,0, 0,0,0,3,2)); // 7 r4 killed, r12 survives
    tab2.push_back(mk(0,0,0,0,0,  0, 0, 0, 0,0, 0,0,0,0,2)); // 8 idle

    // Reset state, with flush raised to see bubble follow it
    reset = 1'b0;
    drive(1'b0, idle);
    drive(1'b1, idle);
    flush1 = 1'b1;
    #3;
    chk("reset.stall",  int'(stall1), 0);
    chk("reset.bubble", int'(bub1),   1);
    chk("reset.fwd_a",  int'(fa1),    0);
    chk("reset.fwd_b",  int'(fb1),    0);
    chk("reset.cnt",    int'(cnt1),   0);
    chk("reset.cnt2",   int'(cnt2),   0);
    flush1 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    foreach (tab1[i]) step(1'b0, tab1[i], $sformatf("d1v%0d", i));

    // Build stall_cnt up to 9 with repeated load-use pairs
    for (int i = 0; i < 6; i++) begin
      step(1'b0, mk(1,1,1,0,0, 0,0,5, 0,0, 0,0,0,0,3+i), $sformatf("acc%0d.lw", i));
      step(1'b0, mk(1,0,0,1,0, 5,0,0, 0,0, 1,1,0,0,3+i), $sformatf("acc%0d.stall", i));
      step(1'b0, mk(1,0,0,1,0, 5,0,0, 0,0, 0,0,2,0,4+i), $sformatf("acc%0d.fwd", i));
    end

    // Asynchronous reset in the middle of a load-use stall
    step(1'b0, mk(1,1,1,0,0, 0,0,5, 0,0, 0,0,0,0,9), "rst.lw");
    drive(1'b0, mk(1,0,0,1,0, 5,0,0, 0,0, 1,1,0,0,9));
    #1;
    check(1'b0, mk(1,0,0,1,0, 5,0,0, 0,0, 1,1,0,0,9), "rst.pre");
    reset = 1'b0;
    #1;
    check(1'b0, mk(1,0,0,1,0, 5,0,0, 0,0, 0,0,0,0,0), "rst.async");
    @(negedge clk);
    check(1'b0, mk(1,0,0,1,0, 5,0,0, 0,0, 0,0,0,0,0), "rst.held");
    reset = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, mk(1,0,0,1,0, 5,0,0, 0,0, 0,0,0,0,0), "rst.after");
    step(1'b0, idle, "rst.idle");

    foreach (tab2[i]) step(1'b1, tab2[i], $sformatf("d2v%0d", i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter STAGES, default 2, meaning in-flight stages tracked after issue (index 0 = E, 1 = M, ...); legal range 1..8.
REQ-002 SHALL have parameter RA_W, default 5, meaning register-address width.
REQ-003 SHALL have parameter LOAD_STAGE, default 1, meaning the first stage index whose load result can be forwarded; legal range 1..STAGES-1 when STAGES>1, else 1.
REQ-004 SHALL have parameter FLUSH_DEPTH, default 1, meaning the number of youngest entries killed by flush; legal range 0..STAGES.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state on rising edge.
REQ-006 SHALL have port reset, input, 1, meaning asynchronous, active-low reset.
REQ-007 SHALL have ports issue_valid, issue_is_load and issue_wen, each input, 1, meaning that an instruction is presented in I, is a load, and writes a register.
REQ-008 SHALL have ports issue_use_rs and issue_use_rt, each input, 1, meaning that operand rs or rt is read.
REQ-009 SHALL have ports issue_rs, issue_rt and issue_rd, each input, RA_W, meaning the source and destination register addresses.
REQ-010 SHALL have port hold_ext, input, 1, meaning memory is not ready, so the whole pipeline freezes.
REQ-011 SHALL have port flush, input, 1, meaning a taken branch or jump redirect.
REQ-012 SHALL have port stall, output, 1, meaning hold the PC and the I/E register.
REQ-013 SHALL have port bubble, output, 1, meaning insert a NOP into E this cycle.
REQ-014 SHALL have ports fwd_a and fwd_b, each output, clog2(STAGES+1), meaning the operand source select: 0 = register file, k = result of stage k-1.
REQ-015 SHALL have port stall_cnt, output, 32, meaning the count of cycles with a load-use stall.

Function
REQ-016 SHALL keep STAGES entries {valid, rd, wen, load}; entry k is the instruction k+1 stages past I.
REQ-017 SHALL define match(k,r) = valid[k] & wen[k] & (rd[k]==r) & (r!=0); register 0 never creates a hazard.
REQ-018 fwd_a SHALL be k+1 for the smallest k with match(k,issue_rs) & issue_use_rs & !(load[k] & k<LOAD_STAGE), else 0; fwd_b SHALL be the same for rt. Youngest match wins.
REQ-019 SHALL assert a load-use stall (lu) when issue_valid and there exists k<LOAD_STAGE with load[k] and a match on a used operand; lu SHALL NOT be asserted when the matching operand is unused.
REQ-020 SHALL drive stall = lu | hold_ext, combinationally with zero-cycle latency.
REQ-021 SHALL drive bubble = (lu | flush) & !hold_ext.
REQ-022 When hold_ext=1, all entries and stall_cnt SHALL hold; hold_ext SHALL override flush and lu.
REQ-023 Otherwise, each edge SHALL shift entries (entry k -> k+1; the oldest is discarded), and entry 0 SHALL load the issue fields when issue_valid & !lu & !flush, else an invalid entry.
REQ-024 flush with hold_ext=0 SHALL clear valid of post-shift entries 0..FLUSH_DEPTH-1, including the new entry 0.
REQ-025 stall_cnt SHALL increment by 1 on each edge with lu & !hold_ext, and SHALL saturate at 32'hFFFFFFFF.
REQ-026 Outputs SHALL depend only on current entries and issue/hold/flush inputs; there is no combinational path from stall to any input.

Reset
REQ-027 reset=0 SHALL immediately clear all valid bits and stall_cnt; with issue_valid=0 and hold_ext=0, stall=0, bubble=flush, fwd_a=fwd_b=0.
REQ-028 Reset SHALL be asynchronous-assert with synchronous-deassert usage assumed from the system reset synchroniser; the first edge after release SHALL behave as REQ-023 from the empty state.
REQ-029 Reset asserted mid-stall SHALL abandon the stall; no pending hazard survives.

Structure
REQ-030 A shared package hazard_pkg SHALL hold the entry record type, the fwd select encoding (FWD_RF=0) and parameter-legality checks.
REQ-031 A single sub-module hazard_match SHALL contain the per-entry comparator (match and load-pending flags), instantiated STAGES times with a generate loop.
REQ-032 Parameter legality violations SHALL fail at elaboration.

Verification
REQ-033 Scenario 1: defaults; issue add rd=3, next cycle issue rs=3 -> fwd_a=1, stall=0; one cycle later with an intervening NOP -> fwd_a=2.
REQ-034 Scenario 2: lw rd=5 then immediate use rt=5 -> stall=1 and bubble=1 for exactly 1 cycle, then fwd_b=2, stall_cnt=1.
REQ-035 Scenario 3: lw rd=5 then a consumer with use_rs=use_rt=0 and rs=5 -> stall=0; rd=0 writer followed by rs=0 reader -> fwd_a=0.
REQ-036 Scenario 4: two writers to r7 in E and M, reader rs=7 -> fwd_a=1 (youngest wins).
REQ-037 Scenario 5: hold_ext=1 for 3 cycles during a load-use -> entries frozen, stall=1, bubble=0, stall_cnt unchanged; the release resumes REQ-034 behaviour.
REQ-038 Scenario 6: flush with E holding writer rd=4, then reader rs=4 -> fwd_a=0; reset pulse with stall_cnt=9 -> stall_cnt=0 asynchronously; STAGES=4, LOAD_STAGE=2 -> a load-use stall of 2 cycles.
